// File: rtl/uart_rx_cfg_pkg.sv
// Shared types, limits and config helpers for the configurable UART receiver.
// Imported by the top-level FSM and the bit sampler.
package uart_rx_cfg_pkg;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t IDLE      = 3'd0;
    localparam rx_state_t START     = 3'd1;
    localparam rx_state_t DATA      = 3'd2;
    localparam rx_state_t PARITY    = 3'd3;
    localparam rx_state_t STOP      = 3'd4;
    localparam rx_state_t WAIT_IDLE = 3'd5;

    localparam logic [3:0]  DATA_LEN_MIN = 4'd5;
    localparam logic [15:0] PRESC_MIN    = 16'd6;

    // Odd ratios lose their LSB; anything below the floor uses the floor.
    function automatic logic [15:0] round_presc(input logic [15:0] p);
        if (p < PRESC_MIN) begin
            return PRESC_MIN;
        end
        return {p[15:1], 1'b0};
    endfunction

    function automatic logic [3:0] clamp_len(
        input logic [3:0] len,
        input logic [3:0] max_len
    );
        if (len < DATA_LEN_MIN) begin
            return DATA_LEN_MIN;
        end
        if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timing for the UART receiver: edge counter, bit counter and
// a 3-tap majority vote around the middle of each bit.
module uart_rx_sampler
    import uart_rx_cfg_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    input  logic               rx_s,
    output logic [3:0]         bit_cnt,
    output logic               wrap,
    output logic               sample_valid,
    output logic               sample_bit
);

    logic [PRESC_W-1:0] edge_cnt;
    logic [PRESC_W-1:0] half;
    logic [2:0]         taps;

    assign half = presc >> 1;
    assign wrap = en && (edge_cnt == presc - PRESC_W'(1));

    assign sample_valid = en && (edge_cnt == half + PRESC_W'(2));
    assign sample_bit   = (taps[0] & taps[1]) |
                          (taps[0] & taps[2]) |
                          (taps[1] & taps[2]);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            taps     <= 3'b111;
        end else if (en) begin
            if (wrap) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + PRESC_W'(1);
            end
            if (edge_cnt == half - PRESC_W'(1)) begin
                taps[0] <= rx_s;
            end
            if (edge_cnt == half) begin
                taps[1] <= rx_s;
            end
            if (edge_cnt == half + PRESC_W'(1)) begin
                taps[2] <= rx_s;
            end
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..DATA_W_MAX data bits, optional
// parity, 1 or 2 stop bits, break detection and split error pulses.
module uart_rx_cfg
    import uart_rx_cfg_pkg::*;
#(
    parameter int DATA_W_MAX = 9,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    Prescale,
    input  logic [3:0]            DATA_LEN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic [DATA_W_MAX-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  brk_det,
    output logic                  busy
);

    localparam logic [3:0] LEN_MAX = 4'(DATA_W_MAX);

    logic sync1;
    logic rx_s;

    rx_state_t state;

    logic [PRESC_W-1:0]    presc_l;
    logic [3:0]            len_l;
    logic                  par_l;
    logic                  typ_l;
    logic                  stop2_l;

    logic [DATA_W_MAX-1:0] shreg;
    logic                  par_bit;
    logic                  par_bad;
    logic                  stp_acc;

    logic [3:0] bit_cnt;
    logic [3:0] last_idx;
    logic       wrap;
    logic       sample_valid;
    logic       sample_bit;
    logic       start_det;
    logic       smp_en;
    logic       stop_bad;
    logic       is_break;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= RX_IN;
            rx_s  <= sync1;
        end
    end

    assign busy      = (state != IDLE);
    assign start_det = (state == IDLE) && !rx_s;
    assign smp_en    = (state == START) || (state == DATA) ||
                       (state == PARITY) || (state == STOP);

    // Bit index of the final stop bit: start is index 0, data from 1.
    assign last_idx = 4'd1 + len_l + {3'b000, par_l} + {3'b000, stop2_l};

    assign stop_bad = stp_acc | ~sample_bit;
    assign is_break = ~sample_bit && (shreg == '0) && !(par_l && par_bit);

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .clk          (CLK),
        .rst_n        (RST),
        .en           (smp_en),
        .clr          (start_det),
        .presc        (presc_l),
        .rx_s         (rx_s),
        .bit_cnt      (bit_cnt),
        .wrap         (wrap),
        .sample_valid (sample_valid),
        .sample_bit   (sample_bit)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            presc_l    <= PRESC_W'(PRESC_MIN);
            len_l      <= DATA_LEN_MIN;
            par_l      <= 1'b0;
            typ_l      <= 1'b0;
            stop2_l    <= 1'b0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            par_bad    <= 1'b0;
            stp_acc    <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            brk_det    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            brk_det    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        presc_l <= PRESC_W'(round_presc(16'(Prescale)));
                        len_l   <= clamp_len(DATA_LEN, LEN_MAX);
                        par_l   <= PAR_EN;
                        typ_l   <= PAR_TYP;
                        stop2_l <= STOP2;
                        shreg   <= '0;
                        par_bit <= 1'b0;
                        par_bad <= 1'b0;
                        stp_acc <= 1'b0;
                    end
                end
                START: begin
                    if (sample_valid && sample_bit) begin
                        state <= IDLE;
                    end else if (wrap) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (sample_valid) begin
                        shreg[bit_cnt - 4'd1] <= sample_bit;
                    end
                    if (wrap && (bit_cnt == len_l)) begin
                        state <= par_l ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (sample_valid) begin
                        par_bit <= sample_bit;
                        par_bad <= sample_bit != ((^shreg) ^ typ_l);
                    end
                    if (wrap) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (sample_valid) begin
                        if (bit_cnt == last_idx) begin
                            if (is_break) begin
                                brk_det <= 1'b1;
                            end else if (par_bad || stop_bad) begin
                                par_err <= par_bad;
                                stp_err <= stop_bad;
                            end else begin
                                data_valid <= 1'b1;
                                P_DATA     <= shreg;
                            end
                            state <= stop_bad ? WAIT_IDLE : IDLE;
                        end else begin
                            stp_acc <= stp_acc | ~sample_bit;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
